fc_layer_sequencer: RTL
=======================

// Module: fc_layer_sequencer
// PURPOSE
//  Wrapper-side controller for the AXIS buffer interface; computes one fully-connected CNN layer.
//  Waits for axisif_start, then for each output neuron walks the input buffer and weight memory,
//  multiply-accumulates onto a bias, writes the saturated result into the output buffer, and pulses axisif_done.
//  Sits between the AXIS interface block and the external weight/bias memories.
// PARAMETERS
//  DATA_WIDTH    32  signed fixed-point word width (activations, weights, bias, results)
//  FRAC_BITS     16  fractional bits of every word (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS)
//  IN_DATA_NUM    8  input vector length (MAC steps per neuron)
//  OUT_DATA_NUM   4  number of output neurons
//  IN_ADR_WIDTH   8  input buffer address width
//  OUT_ADR_WIDTH  8  output buffer / bias address width
//  WGT_ADR_WIDTH  8  weight address width; must be >= clogb2(IN_DATA_NUM*OUT_DATA_NUM)
// PORTS
//  clk                    in   1              clock, rising edge
//  rst_n                  in   1              asynchronous active-low reset
//  axisif_start           in   1              one-cycle start pulse from AXIS interface
//  axisif_done            out  1              one-cycle completion pulse
//  axisif_bufferIn_adr    out  IN_ADR_WIDTH   input buffer read address
//  axisif_bufferIn_data   in   DATA_WIDTH     input buffer read data (1-cycle read latency)
//  axisif_bufferOut_adr   out  OUT_ADR_WIDTH  output buffer write address
//  axisif_bufferOut_data  out  DATA_WIDTH     output buffer write data
//  axisif_bufferOut_wr    out  1              output buffer write strobe
//  wgt_adr                out  WGT_ADR_WIDTH  weight address = o*IN_DATA_NUM + i
//  wgt_data               in   DATA_WIDTH     weight data (1-cycle read latency)
//  bias_adr               out  OUT_ADR_WIDTH  bias address = o
//  bias_data              in   DATA_WIDTH     bias data (1-cycle read latency)
// BEHAVIOUR
//  Reset: state IDLE, counters i,o = 0, accumulator 0; every output 0.
//  FSM IDLE -> LOAD -> MAC -> WRITE -> (LOAD | DONE) -> IDLE.
//   IDLE : wait for axisif_start. Clear o and go to LOAD.
//   LOAD : 1 cycle. Drive bias_adr=o, bufferIn_adr=0, wgt_adr=o*IN_DATA_NUM. Set i=1.
//   MAC  : IN_DATA_NUM cycles, k=1..IN_DATA_NUM.
//          Data returned for index k-1 is multiplied (signed, full 2*DATA_WIDTH product).
//          k=1: acc <= (bias_data <<< FRAC_BITS) + product.
//          k>1: acc <= acc + product.
//          While k<IN_DATA_NUM, issue addresses for index k.
//   WRITE: 1 cycle. bufferOut_wr=1, bufferOut_adr=o, bufferOut_data=result.
//          If o==OUT_DATA_NUM-1 go to DONE; else o++ and go to LOAD.
//   DONE : axisif_done=1 for exactly 1 cycle, then IDLE.
//  Accumulator width: 2*DATA_WIDTH + clogb2(IN_DATA_NUM); it never overflows.
//  result = acc >>> FRAC_BITS (truncate toward -inf), saturated to the signed DATA_WIDTH range.
//  Latency: start sampled at cycle 0 -> axisif_done at cycle OUT_DATA_NUM*(IN_DATA_NUM+2)+1.
//  axisif_start is ignored outside IDLE, including in the DONE cycle.
//  bufferOut_wr is 0 in every state except WRITE.
//  Address outputs are don't-care when not in LOAD/MAC but are held at 0 in IDLE.
//  rst_n low mid-operation: immediate return to IDLE; no write and no done pulse. The next start begins a fresh layer.
// CONFIGURATION
//  FC_SEQ_RELU_EN defined    : after saturation, a negative result is written as 0 (ReLU).
//  FC_SEQ_RELU_EN undefined  : the saturated signed result is written unchanged.
// STRUCTURE
//  Shared package fc_seq_pkg:
//   - state encoding (IDLE, LOAD, MAC, WRITE, DONE; STATE_WIDTH)
//   - clogb2 function
//   - ACC_WIDTH derivation
//   - saturation limits
//  Sub-module fc_mac_unit: signed multiply, accumulate with bias load, shift/saturate/optional ReLU.
//  The FSM and the i/o counters stay in fc_layer_sequencer.
// TESTING  (IN_DATA_NUM=8, OUT_DATA_NUM=4, FRAC_BITS=16, DATA_WIDTH=32)
//  1. All inputs 0x00010000, all weights 0x00010000, bias 0, start at cycle 0
//     -> 4 writes of 0x00080000 to adr 0..3; done high only at cycle 41.
//  2. Weights 0xFFFF0000 (-1.0), inputs 1.0, bias 0x00008000 (0.5)
//     -> 0xFFF88000 without FC_SEQ_RELU_EN; 0x00000000 with it.
//  3. Inputs and weights 0x7FFFFFFF -> writes 0x7FFFFFFF (positive saturation).
//     Inputs 0x80000000 with weights 0x7FFFFFFF -> 0x80000000, or 0 with ReLU.
//  4. Distinct weights w[o][i] = (o*8+i) in Q16, inputs 1.0 -> verify wgt_adr sequence and out[o] = sum_i w[o][i].
//  5. Extra axisif_start pulses during MAC and during DONE -> ignored: exactly 4 writes and 1 done.
//  6. rst_n low for 2 cycles during neuron 1 MAC -> no further wr/done.
//     A new start afterwards gives the results of test 1 with the same cycle timing.

Source files
------------

// File: rtl/fc_seq_pkg.sv
// Shared definitions for the fully-connected layer sequencer: FSM state
// encoding, the clogb2 helper, accumulator sizing and saturation limits.
package fc_seq_pkg;

    localparam int STATE_WIDTH = 3;

    typedef enum logic [STATE_WIDTH-1:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MAC   = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Smallest r with 2**r >= value (0 for value <= 1).
    function automatic int clogb2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    // Full product width plus growth for summing in_num products, which keeps
    // the accumulator free of overflow for any input data.
    function automatic int acc_width(input int data_width, input int in_num);
        return 2 * data_width + clogb2(in_num);
    endfunction

    // Largest value representable in a signed data_width word.
    function automatic longint sat_max(input int data_width);
        return (longint'(1) <<< (data_width - 1)) - 1;
    endfunction

    // Smallest value representable in a signed data_width word.
    function automatic longint sat_min(input int data_width);
        return -(longint'(1) <<< (data_width - 1));
    endfunction

endpackage

// File: rtl/fc_mac_unit.sv
// Signed multiply-accumulate datapath for one output neuron: loads the bias
// together with the first product, accumulates the rest, then rescales and
// saturates the sum to a DATA_WIDTH word.
// Optional macro FC_SEQ_RELU_EN: negative saturated results are clamped to 0.
module fc_mac_unit
    import fc_seq_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int FRAC_BITS   = 16,
    parameter int IN_DATA_NUM = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  accumulate,
    input  logic [DATA_WIDTH-1:0] bias,
    input  logic [DATA_WIDTH-1:0] act,
    input  logic [DATA_WIDTH-1:0] wgt,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, IN_DATA_NUM);
    localparam logic signed [ACC_WIDTH-1:0] RES_MAX = ACC_WIDTH'(sat_max(DATA_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] RES_MIN = ACC_WIDTH'(sat_min(DATA_WIDTH));

    logic signed [2*DATA_WIDTH-1:0] product;
    logic signed [ACC_WIDTH-1:0]    bias_term;
    logic signed [ACC_WIDTH-1:0]    acc;
    logic signed [ACC_WIDTH-1:0]    shifted;
    logic        [DATA_WIDTH-1:0]   clipped;

    assign product   = $signed(act) * $signed(wgt);
    assign bias_term = ACC_WIDTH'($signed(bias)) <<< FRAC_BITS;

    // Accumulator: first MAC step restarts from the aligned bias, later steps add on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (load) begin
            acc <= bias_term + ACC_WIDTH'(product);
        end else if (accumulate) begin
            acc <= acc + ACC_WIDTH'(product);
        end
    end

    // Drop the extra fraction bits (floor), clip to the word range, optional ReLU.
    always_comb begin
        shifted = acc >>> FRAC_BITS;
        if (shifted > RES_MAX) begin
            clipped = RES_MAX[DATA_WIDTH-1:0];
        end else if (shifted < RES_MIN) begin
            clipped = RES_MIN[DATA_WIDTH-1:0];
        end else begin
            clipped = shifted[DATA_WIDTH-1:0];
        end
`ifdef FC_SEQ_RELU_EN
        result = clipped[DATA_WIDTH-1] ? '0 : clipped;
`else
        result = clipped;
`endif
    end

endmodule

// File: rtl/fc_layer_sequencer.sv
// Controller for one fully-connected layer behind the AXIS buffer interface.
// Per output neuron: LOAD issues the first addresses, MAC runs IN_DATA_NUM
// accumulate steps against 1-cycle-latency memories, WRITE stores the result;
// after the last neuron DONE pulses axisif_done.
// Optional macro FC_SEQ_RELU_EN (used in fc_mac_unit): ReLU on written results.
module fc_layer_sequencer
    import fc_seq_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int FRAC_BITS     = 16,
    parameter int IN_DATA_NUM   = 8,
    parameter int OUT_DATA_NUM  = 4,
    parameter int IN_ADR_WIDTH  = 8,
    parameter int OUT_ADR_WIDTH = 8,
    parameter int WGT_ADR_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     axisif_start,
    output logic                     axisif_done,
    output logic [IN_ADR_WIDTH-1:0]  axisif_bufferIn_adr,
    input  logic [DATA_WIDTH-1:0]    axisif_bufferIn_data,
    output logic [OUT_ADR_WIDTH-1:0] axisif_bufferOut_adr,
    output logic [DATA_WIDTH-1:0]    axisif_bufferOut_data,
    output logic                     axisif_bufferOut_wr,
    output logic [WGT_ADR_WIDTH-1:0] wgt_adr,
    input  logic [DATA_WIDTH-1:0]    wgt_data,
    output logic [OUT_ADR_WIDTH-1:0] bias_adr,
    input  logic [DATA_WIDTH-1:0]    bias_data
);

    localparam int I_WIDTH = clogb2(IN_DATA_NUM + 1);
    localparam int O_WIDTH = (OUT_DATA_NUM > 1) ? clogb2(OUT_DATA_NUM) : 1;
    localparam logic [I_WIDTH-1:0] I_ONE  = I_WIDTH'(1);
    localparam logic [I_WIDTH-1:0] I_LAST = I_WIDTH'(IN_DATA_NUM);
    localparam logic [O_WIDTH-1:0] O_ONE  = O_WIDTH'(1);
    localparam logic [O_WIDTH-1:0] O_LAST = O_WIDTH'(OUT_DATA_NUM - 1);

    state_t               state;
    state_t               next_state;
    logic [I_WIDTH-1:0]   i_cnt;
    logic [O_WIDTH-1:0]   o_cnt;
    logic                 addr_valid;
    logic [I_WIDTH-1:0]   addr_idx;
    logic                 mac_load;
    logic                 mac_acc;
    logic [DATA_WIDTH-1:0] mac_result;

    // State register; reset aborts any layer in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // i counts MAC steps within a neuron, o selects the neuron being computed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_cnt <= '0;
            o_cnt <= '0;
        end else begin
            case (state)
                IDLE:    if (axisif_start) o_cnt <= '0;
                LOAD:    i_cnt <= I_ONE;
                MAC:     if (i_cnt != I_LAST) i_cnt <= i_cnt + I_ONE;
                WRITE:   if (o_cnt != O_LAST) o_cnt <= o_cnt + O_ONE;
                default: ;
            endcase
        end
    end

    // Next-state decode plus the strobes and write port driven by each state.
    always_comb begin
        next_state            = state;
        addr_valid            = 1'b0;
        addr_idx              = '0;
        mac_load              = 1'b0;
        mac_acc               = 1'b0;
        axisif_done           = 1'b0;
        axisif_bufferOut_wr   = 1'b0;
        axisif_bufferOut_adr  = '0;
        axisif_bufferOut_data = '0;
        case (state)
            IDLE: begin
                if (axisif_start) next_state = LOAD;
            end
            LOAD: begin
                addr_valid = 1'b1;
                next_state = MAC;
            end
            MAC: begin
                mac_acc  = 1'b1;
                mac_load = (i_cnt == I_ONE);
                if (i_cnt == I_LAST) begin
                    next_state = WRITE;
                end else begin
                    addr_valid = 1'b1;
                    addr_idx   = i_cnt;
                end
            end
            WRITE: begin
                axisif_bufferOut_wr   = 1'b1;
                axisif_bufferOut_adr  = OUT_ADR_WIDTH'(o_cnt);
                axisif_bufferOut_data = mac_result;
                next_state            = (o_cnt == O_LAST) ? DONE : LOAD;
            end
            DONE: begin
                axisif_done = 1'b1;
                next_state  = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign axisif_bufferIn_adr = addr_valid ? IN_ADR_WIDTH'(addr_idx) : '0;
    assign wgt_adr = addr_valid
                   ? WGT_ADR_WIDTH'(o_cnt) * WGT_ADR_WIDTH'(IN_DATA_NUM) + WGT_ADR_WIDTH'(addr_idx)
                   : '0;
    assign bias_adr = (state == LOAD || state == MAC) ? OUT_ADR_WIDTH'(o_cnt) : '0;

    fc_mac_unit #(
        .DATA_WIDTH  (DATA_WIDTH),
        .FRAC_BITS   (FRAC_BITS),
        .IN_DATA_NUM (IN_DATA_NUM)
    ) u_mac (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (mac_load),
        .accumulate (mac_acc),
        .bias       (bias_data),
        .act        (axisif_bufferIn_data),
        .wgt        (wgt_data),
        .result     (mac_result)
    );

endmodule
